vdp18_addr_gen: RTL and testbench

VDP18_ADDR_GEN -- requirements
Module: vdp18_addr_gen

---
 rtl/vdp18_addr_gen.sv | 207 ++++++++++++++++++++
 tb/tb_vdp18_addr_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp18_addr_gen.sv
// VRAM address generator for a TMS9918-style VDP: composes video fetch
// addresses per slot type and arbitrates CPU data-port accesses.

package vdp18_pkg;
    typedef enum logic [3:0] {
        AC_NONE, AC_CPU, AC_PNT, AC_PCT, AC_PGT, AC_STST, AC_SATY,
        AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL
    } access_t;

    typedef enum logic [1:0] {TEXTM, GRAPH1, GRAPH2, MULTIC} opmode_t;
endpackage

module vdp18_addr_gen
    import vdp18_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                                          clock_i,
    input  logic                                          reset_n_i,
    input  logic                                          clk_en_i,
    input  access_t                                       access_type_i,
    input  opmode_t                                       opmode_i,
    input  logic [8:0]                                    num_line_i,
    input  logic [3:0]                                    reg_ntb_i,
    input  logic [7:0]                                    reg_ctb_i,
    input  logic [2:0]                                    reg_pgb_i,
    input  logic [6:0]                                    reg_satb_i,
    input  logic [2:0]                                    reg_spgb_i,
    input  logic                                          reg_size1_i,
    input  logic [((ADDR_W > 14) ? (ADDR_W - 14) : 1)-1:0] reg_ext_i,
    input  logic [9:0]                                    pat_table_i,
    input  logic [7:0]                                    pat_name_i,
    input  logic [4:0]                                    spr_num_i,
    input  logic [3:0]                                    spr_line_i,
    input  logic [7:0]                                    spr_name_i,
    input  logic                                          cpu_ctrl_wr_i,
    input  logic                                          cpu_data_wr_i,
    input  logic                                          cpu_data_rd_i,
    input  logic [7:0]                                    cpu_d_i,
    output logic [ADDR_W-1:0]                             vram_a_o,
    output logic                                          vram_vld_o,
    output logic                                          vram_we_o,
    output logic                                          cpu_busy_o,
    output logic                                          cpu_ovr_o,
    output logic                                          reg_wr_o
);

    localparam int EXT_W = ADDR_W - 14;

    typedef enum logic {WAIT_LO, WAIT_HI} ctrl_state_t;
    typedef enum logic [1:0] {IDLE, PEND_RD, PEND_WR} req_state_t;

    ctrl_state_t       ctrl_q, ctrl_d;
    req_state_t        req_q, req_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, load_val;
    logic              ovr_q, ovr_d, reg_wr_q, reg_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, vid_addr;
    logic              vld_q, vld_d, we_q, we_d;
    logic [13:0]       vid_lo;
    logic              vid_hit, serve, prefetch, new_req;
    logic              unused_bits;

    assign unused_bits = ^{num_line_i[8], reg_ext_i};

    // Low 14 address bits for video slots; vid_hit marks slot types that fetch.
    always_comb begin
        vid_lo  = '0;
        vid_hit = 1'b1;
        case (access_type_i)
            AC_PNT: vid_lo = {reg_ntb_i, pat_table_i};
            AC_PCT: begin
                case (opmode_i)
                    GRAPH1: vid_lo = {reg_ctb_i, 1'b0, pat_name_i[7:3]};
                    GRAPH2: vid_lo = {reg_ctb_i[7], num_line_i[7:6] & reg_ctb_i[6:5],
                                      pat_name_i & {reg_ctb_i[4:0], 3'b111}, num_line_i[2:0]};
                    default: vid_hit = 1'b0;
                endcase
            end
            AC_PGT: begin
                case (opmode_i)
                    MULTIC: vid_lo = {reg_pgb_i, pat_name_i, num_line_i[4:2]};
                    GRAPH2: vid_lo = {reg_pgb_i[2], num_line_i[7:6] & reg_pgb_i[1:0],
                                      pat_name_i & {reg_ctb_i[4:0], 3'b111}, num_line_i[2:0]};
                    default: vid_lo = {reg_pgb_i, pat_name_i, num_line_i[2:0]};
                endcase
            end
            AC_STST, AC_SATY: vid_lo = {reg_satb_i, spr_num_i, 2'b00};
            AC_SATX: vid_lo = {reg_satb_i, spr_num_i, 2'b01};
            AC_SATN: vid_lo = {reg_satb_i, spr_num_i, 2'b10};
            AC_SATC: vid_lo = {reg_satb_i, spr_num_i, 2'b11};
            AC_SPTH: vid_lo = reg_size1_i ? {reg_spgb_i, spr_name_i[7:2], 1'b0, spr_line_i}
                                          : {reg_spgb_i, spr_name_i, spr_line_i[2:0]};
            AC_SPTL: vid_lo = {reg_spgb_i, spr_name_i[7:2], 1'b1, spr_line_i};
            default: vid_hit = 1'b0;
        endcase
    end

    generate
        if (EXT_W > 0) begin : g_ext
            assign vid_addr = {reg_ext_i, vid_lo};
        end else begin : g_no_ext
            assign vid_addr = vid_lo;
        end
    endgenerate

    // Control-port byte pairing and CPU request tracking. A pointer load on the
    // same edge as a service takes precedence over the post-access increment.
    always_comb begin
        ctrl_d   = ctrl_q;
        req_d    = req_q;
        lo_d     = lo_q;
        ptr_d    = ptr_q;
        ovr_d    = ovr_q;
        reg_wr_d = 1'b0;
        prefetch = 1'b0;
        load_val = '0;
        load_val[13:0] = {cpu_d_i[5:0], lo_q};
        serve    = clk_en_i && (access_type_i == AC_CPU) && (req_q != IDLE);

        if (serve) begin
            req_d = IDLE;
            ptr_d = ptr_q + 1'b1;
        end

        if (cpu_ctrl_wr_i) begin
            if (ctrl_q == WAIT_LO) begin
                lo_d   = cpu_d_i;
                ctrl_d = WAIT_HI;
            end else begin
                ctrl_d = WAIT_LO;
                case (cpu_d_i[7:6])
                    2'b00: begin
                        ptr_d    = load_val;
                        prefetch = 1'b1;
                    end
                    2'b01:   ptr_d    = load_val;
                    2'b10:   reg_wr_d = 1'b1;
                    default: ;
                endcase
            end
        end

        if (cpu_data_wr_i || cpu_data_rd_i) begin
            ctrl_d = WAIT_LO;
        end

        new_req = cpu_data_wr_i || cpu_data_rd_i || prefetch;
        if (new_req) begin
            if (req_q == IDLE || serve) begin
                req_d = cpu_data_wr_i ? PEND_WR : PEND_RD;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        addr_d = '0;
        vld_d  = 1'b0;
        we_d   = 1'b0;
        if (access_type_i == AC_CPU) begin
            if (req_q != IDLE) begin
                addr_d = ptr_q;
                vld_d  = 1'b1;
                we_d   = (req_q == PEND_WR);
            end
        end else if (vid_hit) begin
            addr_d = vid_addr;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctrl_q   <= WAIT_LO;
            req_q    <= IDLE;
            lo_q     <= '0;
            ptr_q    <= '0;
            ovr_q    <= 1'b0;
            reg_wr_q <= 1'b0;
            addr_q   <= '0;
            vld_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            req_q    <= req_d;
            lo_q     <= lo_d;
            ptr_q    <= ptr_d;
            ovr_q    <= ovr_d;
            reg_wr_q <= reg_wr_d;
            if (clk_en_i) begin
                addr_q <= addr_d;
                vld_q  <= vld_d;
                we_q   <= we_d;
            end
        end
    end

    assign vram_a_o   = addr_q;
    assign vram_vld_o = vld_q;
    assign vram_we_o  = we_q;
    assign cpu_busy_o = (req_q != IDLE);
    assign cpu_ovr_o  = ovr_q;
    assign reg_wr_o   = reg_wr_q;

endmodule

// File: tb/tb_vdp18_addr_gen.sv
// Directed self-checking bench for vdp18_addr_gen: a 14-bit instance for
// address composition and CPU arbitration, a 16-bit one for upper bits and wrap.

module tb_vdp18_addr_gen;
    import vdp18_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        clk_en = 1'b0;
    access_t     access_type = AC_NONE;
    opmode_t     opmode = GRAPH1;
    logic [8:0]  num_line = '0;
    logic [3:0]  ntb = '0;
    logic [7:0]  ctb = '0;
    logic [2:0]  pgb = '0;
    logic [6:0]  satb = '0;
    logic [2:0]  spgb = '0;
    logic        size1 = 1'b0;
    logic [0:0]  ext14 = 1'b0;
    logic [1:0]  ext16 = 2'b10;
    logic [9:0]  pat_table = '0;
    logic [7:0]  pat_name = '0;
    logic [4:0]  spr_num = '0;
    logic [3:0]  spr_line = '0;
    logic [7:0]  spr_name = '0;
    logic        ctrl_wr = 1'b0, data_wr = 1'b0, data_rd = 1'b0;
    logic [7:0]  cpu_d = '0;
    logic        ctrl_wr16 = 1'b0, data_wr16 = 1'b0, data_rd16 = 1'b0;
    logic [7:0]  cpu_d16 = '0;

    logic [13:0] a14;
    logic        vld14, we14, busy14, ovr14, regwr14;
    logic [15:0] a16;
    logic        vld16, we16, busy16, ovr16, regwr16;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    vdp18_addr_gen #(.ADDR_W(14)) dut14 (
        .clock_i(clock), .reset_n_i(reset_n), .clk_en_i(clk_en),
        .access_type_i(access_type), .opmode_i(opmode), .num_line_i(num_line),
        .reg_ntb_i(ntb), .reg_ctb_i(ctb), .reg_pgb_i(pgb), .reg_satb_i(satb),
        .reg_spgb_i(spgb), .reg_size1_i(size1), .reg_ext_i(ext14),
        .pat_table_i(pat_table), .pat_name_i(pat_name), .spr_num_i(spr_num),
        .spr_line_i(spr_line), .spr_name_i(spr_name),
        .cpu_ctrl_wr_i(ctrl_wr), .cpu_data_wr_i(data_wr), .cpu_data_rd_i(data_rd),
        .cpu_d_i(cpu_d),
        .vram_a_o(a14), .vram_vld_o(vld14), .vram_we_o(we14),
        .cpu_busy_o(busy14), .cpu_ovr_o(ovr14), .reg_wr_o(regwr14)
    );

    vdp18_addr_gen #(.ADDR_W(16)) dut16 (
        .clock_i(clock), .reset_n_i(reset_n), .clk_en_i(clk_en),
        .access_type_i(access_type), .opmode_i(opmode), .num_line_i(num_line),
        .reg_ntb_i(ntb), .reg_ctb_i(ctb), .reg_pgb_i(pgb), .reg_satb_i(satb),
        .reg_spgb_i(spgb), .reg_size1_i(size1), .reg_ext_i(ext16),
        .pat_table_i(pat_table), .pat_name_i(pat_name), .spr_num_i(spr_num),
        .spr_line_i(spr_line), .spr_name_i(spr_name),
        .cpu_ctrl_wr_i(ctrl_wr16), .cpu_data_wr_i(data_wr16), .cpu_data_rd_i(data_rd16),
        .cpu_d_i(cpu_d16),
        .vram_a_o(a16), .vram_vld_o(vld16), .vram_we_o(we16),
        .cpu_busy_o(busy16), .cpu_ovr_o(ovr16), .reg_wr_o(regwr16)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [13:0] addr, input logic vld, input logic we);
        check_output({tag, "_addr"}, 32'(a14), 32'(addr));
        check_output({tag, "_vld"}, 32'(vld14), 32'(vld));
        check_output({tag, "_we"}, 32'(we14), 32'(we));
    endtask

    // One enabled slot of the given type, then back to a disabled idle slot.
    task automatic apply_stimulus(input access_t acc);
        access_type = acc;
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        access_type = AC_NONE;
    endtask

    task automatic ctrl_write(input logic [7:0] b);
        cpu_d = b;
        ctrl_wr = 1'b1;
        tick();
        ctrl_wr = 1'b0;
    endtask

    task automatic data_strobe(input logic is_write);
        data_wr = is_write;
        data_rd = !is_write;
        tick();
        data_wr = 1'b0;
        data_rd = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_addr", 32'(a14), 0);
        check_output("rst_vld", 32'(vld14), 0);
        check_output("rst_we", 32'(we14), 0);
        check_output("rst_busy", 32'(busy14), 0);
        check_output("rst_ovr", 32'(ovr14), 0);
        check_output("rst_regwr", 32'(regwr14), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        ntb = 4'hA; pat_table = 10'h155;
        apply_stimulus(AC_PNT);
        check_slot("pnt", 14'h2955, 1, 0);
        check_output("pnt_ext16", 32'(a16), 32'hA955);

        access_type = AC_SATC; clk_en = 1'b0;
        tick();
        access_type = AC_NONE;
        check_slot("hold_no_en", 14'h2955, 1, 0);

        ctb = 8'h5A; pat_name = 8'hA5; opmode = GRAPH1;
        apply_stimulus(AC_PCT);
        check_slot("pct_g1", 14'h1694, 1, 0);

        opmode = GRAPH2; ctb = 8'h9F; num_line = 9'h0C7;
        apply_stimulus(AC_PCT);
        check_slot("pct_g2_9f", 14'h252F, 1, 0);
        ctb = 8'hBF;
        apply_stimulus(AC_PCT);
        check_slot("pct_g2_bf", 14'h2D2F, 1, 0);
        ctb = 8'h83;
        apply_stimulus(AC_PCT);
        check_slot("pct_g2_mask", 14'h202F, 1, 0);

        opmode = TEXTM;
        apply_stimulus(AC_PCT);
        check_slot("pct_textm", 14'h0000, 0, 0);

        pgb = 3'd5; pat_name = 8'h3C; num_line = 9'h0C5; opmode = GRAPH1;
        apply_stimulus(AC_PGT);
        check_slot("pgt_g1", 14'h29E5, 1, 0);
        opmode = MULTIC;
        apply_stimulus(AC_PGT);
        check_slot("pgt_mc", 14'h29E1, 1, 0);
        opmode = GRAPH2; pgb = 3'd6; ctb = 8'h9F; pat_name = 8'hA5; num_line = 9'h0C7;
        apply_stimulus(AC_PGT);
        check_slot("pgt_g2", 14'h352F, 1, 0);

        satb = 7'h55; spr_num = 5'h13;
        apply_stimulus(AC_STST);
        check_slot("stst", 14'h2ACC, 1, 0);
        apply_stimulus(AC_SATX);
        check_slot("satx", 14'h2ACD, 1, 0);
        apply_stimulus(AC_SATN);
        check_slot("satn", 14'h2ACE, 1, 0);
        apply_stimulus(AC_SATC);
        check_slot("satc", 14'h2ACF, 1, 0);

        spgb = 3'd3; spr_name = 8'h82; spr_line = 4'hD; size1 = 1'b0;
        apply_stimulus(AC_SPTH);
        check_slot("spth_8", 14'h1C15, 1, 0);
        size1 = 1'b1;
        apply_stimulus(AC_SPTH);
        check_slot("spth_16", 14'h1C0D, 1, 0);
        apply_stimulus(AC_SPTL);
        check_slot("sptl", 14'h1C1D, 1, 0);

        apply_stimulus(AC_NONE);
        check_slot("other", 14'h0000, 0, 0);
        apply_stimulus(AC_CPU);
        check_slot("cpu_idle", 14'h0000, 0, 0);

        ctrl_write(8'h34);
        ctrl_write(8'h52);
        check_output("ptr_load_busy", 32'(busy14), 0);
        data_strobe(1'b1);
        check_output("wr_busy", 32'(busy14), 1);
        access_type = AC_CPU; clk_en = 1'b0;
        tick();
        check_output("cpu_no_en_busy", 32'(busy14), 1);
        apply_stimulus(AC_PNT);
        check_output("video_slot_busy", 32'(busy14), 1);
        apply_stimulus(AC_CPU);
        check_slot("cpu_wr", 14'h1234, 1, 1);
        check_output("wr_done_busy", 32'(busy14), 0);
        data_strobe(1'b0);
        apply_stimulus(AC_CPU);
        check_slot("cpu_rd_inc", 14'h1235, 1, 0);

        ctrl_write(8'h07);
        ctrl_write(8'h81);
        check_output("regwr_pulse", 32'(regwr14), 1);
        tick();
        check_output("regwr_end", 32'(regwr14), 0);
        data_strobe(1'b0);
        apply_stimulus(AC_CPU);
        check_slot("after_regwr", 14'h1236, 1, 0);

        data_strobe(1'b1);
        data_strobe(1'b1);
        check_output("ovr_set", 32'(ovr14), 1);
        apply_stimulus(AC_CPU);
        check_slot("ovr_one_access", 14'h1237, 1, 1);
        apply_stimulus(AC_CPU);
        check_slot("ovr_no_second", 14'h0000, 0, 0);
        check_output("ovr_sticky", 32'(ovr14), 1);

        reset_n = 1'b0;
        #1;
        check_output("ovr_reset", 32'(ovr14), 0);
        tick();
        reset_n = 1'b1;

        ctrl_write(8'h00);
        ctrl_write(8'h41);
        ctrl_write(8'h55);
        ctrl_write(8'hFF);
        check_output("code11_busy", 32'(busy14), 0);
        data_strobe(1'b0);
        apply_stimulus(AC_CPU);
        check_slot("code11_ignored", 14'h0100, 1, 0);

        ctrl_write(8'h22);
        data_strobe(1'b0);
        apply_stimulus(AC_CPU);
        check_slot("rd_mid_ctrl", 14'h0101, 1, 0);
        ctrl_write(8'h78);
        ctrl_write(8'h40);
        data_strobe(1'b0);
        apply_stimulus(AC_CPU);
        check_slot("ctrl_resync", 14'h0078, 1, 0);

        ctrl_write(8'h00);
        ctrl_write(8'h00);
        check_output("prefetch_busy", 32'(busy14), 1);
        access_type = AC_CPU; clk_en = 1'b1; data_rd = 1'b1;
        tick();
        data_rd = 1'b0; clk_en = 1'b0; access_type = AC_NONE;
        check_slot("prefetch", 14'h0000, 1, 0);
        check_output("serve_strobe_busy", 32'(busy14), 1);
        check_output("serve_strobe_ovr", 32'(ovr14), 0);
        apply_stimulus(AC_CPU);
        check_slot("second_rd", 14'h0001, 1, 0);

        data_strobe(1'b1);
        reset_n = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(busy14), 0);
        tick();
        reset_n = 1'b1;
        apply_stimulus(AC_CPU);
        check_slot("rst_dropped", 14'h0000, 0, 0);

        cpu_d16 = 8'hFF; ctrl_wr16 = 1'b1; tick();
        cpu_d16 = 8'h7F; tick();
        ctrl_wr16 = 1'b0;
        data_rd16 = 1'b1; tick();
        access_type = AC_CPU; clk_en = 1'b1;
        tick();
        check_output("w16_first", 32'(a16), 32'h3FFF);
        repeat (49151) tick();
        data_rd16 = 1'b0;
        tick();
        check_output("w16_top_addr", 32'(a16), 32'hFFFF);
        check_output("w16_top_vld", 32'(vld16), 1);
        check_output("w16_top_we", 32'(we16), 0);
        check_output("w16_top_busy", 32'(busy16), 0);
        clk_en = 1'b0; data_rd16 = 1'b1; tick();
        data_rd16 = 1'b0; clk_en = 1'b1;
        tick();
        clk_en = 1'b0; access_type = AC_NONE;
        check_output("w16_wrap_addr", 32'(a16), 32'h0000);
        check_output("w16_wrap_vld", 32'(vld16), 1);
        check_output("w16_ovr", 32'(ovr16), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
